// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and sizing helpers for the sync_fifo slice.
//   DEFAULT_*     : default word width / address width used by sync_fifo
//   fifo_depth()  : number of entries for a given address width
//   ptr_width()   : pointer width (address bits plus one wrap bit)
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_ASIZE = 4;
  localparam int unsigned DEFAULT_DEPTH      = 2 ** DEFAULT_FIFO_ASIZE;
  localparam int unsigned DEFAULT_PTR_WIDTH  = DEFAULT_FIFO_ASIZE + 1;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  // The extra MSB distinguishes full from empty when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned asize);
    return asize + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH register file for sync_fifo.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : combinational read data
// Contents are deliberately not reset; the pointers in the top level define
// which entries are valid.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_FIFO_ASIZE
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   in_clock  : clock, all state changes on the rising edge
//   in_reset  : asynchronous active-high reset (clears pointers)
//   in_put    : write request
//   in_take   : pop request
//   in_data   : write data
//   out_data  : head-of-queue word, zero while empty
//   out_empty : FIFO holds no entries
//   out_full  : FIFO holds DEPTH entries
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_ASIZE = DEFAULT_FIFO_ASIZE
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_put,
  input  logic                  in_take,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_empty,
  output logic                  out_full
);

  localparam int unsigned PTR_W = ptr_width(FIFO_ASIZE);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  empty, full;
  logic                  put_acc, take_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags decode the registered pointers only.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_ASIZE-1:0] == rd_ptr_q[FIFO_ASIZE-1:0]) &&
                 (wr_ptr_q[FIFO_ASIZE] != rd_ptr_q[FIFO_ASIZE]);

  // A put while full is still accepted when a take frees the head slot in
  // the same edge; full implies non-empty, so that take is always accepted.
  assign take_acc = in_take && !empty;
  assign put_acc  = in_put && (!full || take_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (put_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (take_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ASIZE)
  ) u_mem (
    .clk   (in_clock),
    .we    (put_acc),
    .waddr (wr_ptr_q[FIFO_ASIZE-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[FIFO_ASIZE-1:0]),
    .rdata (rd_data)
  );

  assign out_data  = empty ? '0 : rd_data;
  assign out_empty = empty;
  assign out_full  = full;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (8-bit, depth 16).
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       put;
  logic       take;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty;
  logic       full;

  int unsigned n_tests;
  int unsigned n_fail;

  sync_fifo #(
    .DATA_WIDTH (8),
    .FIFO_ASIZE (4)
  ) dut (
    .in_clock  (clk),
    .in_reset  (rst),
    .in_put    (put),
    .in_take   (take),
    .in_data   (din),
    .out_data  (dout),
    .out_empty (empty),
    .out_full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wr5 [5];
  logic [7:0] exp_q [$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    put  = 1'b0;
    take = 1'b0;
    din  = 8'h00;
    wr5[0] = 8'h03; wr5[1] = 8'h11; wr5[2] = 8'h22; wr5[3] = 8'h33; wr5[4] = 8'h44;

    // Reset held for 3 cycles.
    repeat (3) tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_data",  {24'd0, dout},  32'h00);
    rst = 1'b0;
    tick();
    check("post_rst_empty", {31'd0, empty}, 32'd1);
    check("post_rst_data",  {24'd0, dout},  32'h00);

    // Five puts, one every other cycle; head stays at the first word.
    for (int i = 0; i < 5; i++) begin
      put = 1'b1;
      din = wr5[i];
      tick();
      put = 1'b0;
      check("wr5_empty", {31'd0, empty}, 32'd0);
      check("wr5_head",  {24'd0, dout},  32'h03);
      check("wr5_full",  {31'd0, full},  32'd0);
      tick();
    end

    // Two takes step the head 0x03 -> 0x11 -> 0x22.
    take = 1'b1; tick(); take = 1'b0;
    check("take1_head", {24'd0, dout}, 32'h11);
    tick();
    take = 1'b1; tick(); take = 1'b0;
    check("take2_head", {24'd0, dout}, 32'h22);

    // 20 consecutive puts from occupancy 3: full after the 13th, rest dropped.
    put = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'h50 + 8'(i);
      tick();
      check("fill_full", {31'd0, full}, (i >= 12) ? 32'd1 : 32'd0);
    end
    put = 1'b0;
    check("fill_head", {24'd0, dout}, 32'h22);

    // Put + take while full: occupancy stays 16, head advances.
    put = 1'b1; take = 1'b1; din = 8'hAA;
    tick();
    put = 1'b0; take = 1'b0;
    check("pt_full_full", {31'd0, full},  32'd1);
    check("pt_full_head", {24'd0, dout},  32'h33);

    // Drain all 16 entries in order.
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    for (int i = 0; i < 13; i++) exp_q.push_back(8'h50 + 8'(i));
    exp_q.push_back(8'hAA);
    take = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_data", {24'd0, dout}, {24'd0, exp_q[i]});
      check("drain_empty", {31'd0, empty}, 32'd0);
      tick();
    end
    take = 1'b0;
    check("drained_empty", {31'd0, empty}, 32'd1);
    check("drained_data",  {24'd0, dout},  32'h00);

    // Take on empty is ignored.
    take = 1'b1; tick(); take = 1'b0;
    check("uf_empty", {31'd0, empty}, 32'd1);
    check("uf_full",  {31'd0, full},  32'd0);

    // Put + take on empty: only the put lands.
    put = 1'b1; take = 1'b1; din = 8'h77;
    tick();
    put = 1'b0; take = 1'b0;
    check("pt_empty_empty", {31'd0, empty}, 32'd0);
    check("pt_empty_data",  {24'd0, dout},  32'h77);
    take = 1'b1; tick(); take = 1'b0;
    check("pt_empty_occ1", {31'd0, empty}, 32'd1);

    // Mid-stream asynchronous reset with 3 words held.
    put = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din = 8'(i);
      tick();
    end
    put = 1'b0;
    check("pre_arst_empty", {31'd0, empty}, 32'd0);
    check("pre_arst_data",  {24'd0, dout},  32'h01);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", {31'd0, empty}, 32'd1);
    check("arst_data",  {24'd0, dout},  32'h00);
    tick();
    rst = 1'b0;
    tick();
    check("arst_post_empty", {31'd0, empty}, 32'd1);
    put = 1'b1; din = 8'h99;
    tick();
    put = 1'b0;
    check("arst_resume_data", {24'd0, dout}, 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
